// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ADDR_W   : PC / instruction-memory address width
//   INST_W   : instruction width
//   RESET_PC : first fetch address after reset
//   ifu_state_e : fetch FSM states (IDLE/REQ/WAIT/HOLD)
//   pc_sel_e    : next-PC mux select for the PC register
//   inst_pkt_t  : instruction + PC payload handed to decode
package ysyx_22040895_ifu_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INST_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'b00,
        IFU_REQ  = 2'b01,
        IFU_WAIT = 2'b10,
        IFU_HOLD = 2'b11
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_KEEP  = 2'b00,
        PC_INC   = 2'b01,
        PC_REDIR = 2'b10
    } pc_sel_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } inst_pkt_t;

endpackage

// File: rtl/ysyx_22040895_ifu_if.sv
// Bundle of the IFU's external handshakes: EXU redirect, instruction-memory
// request/response and the instruction stream to IDU.
//   master : IFU side (drives imem request and instruction outputs)
//   slave  : environment side (EXU, memory, IDU)
interface ysyx_22040895_ifu_if;
    import ysyx_22040895_ifu_pkg::*;

    logic              jump_branch_i_ifu;
    logic [ADDR_W-1:0] dnpc_i_ifu;
    logic              imem_req_valid_o;
    logic              imem_req_ready_i;
    logic [ADDR_W-1:0] imem_req_addr_o;
    logic              imem_rsp_valid_i;
    logic [INST_W-1:0] imem_rsp_data_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;

    modport master (
        input  jump_branch_i_ifu, dnpc_i_ifu,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  inst_ready_i,
        output imem_req_valid_o, imem_req_addr_o,
        output inst_valid_o, inst_o, pc_o
    );

    modport slave (
        output jump_branch_i_ifu, dnpc_i_ifu,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output inst_ready_i,
        input  imem_req_valid_o, imem_req_addr_o,
        input  inst_valid_o, inst_o, pc_o
    );

endinterface

// File: rtl/ysyx_22040895_pcreg.sv
// Architectural PC register with its next-PC mux (hold / +4 / redirect).
//   clk, rst   : clock, async active-high reset (PC returns to RESET_PC)
//   i_sel      : next-PC select
//   i_dnpc     : redirect target, taken verbatim
//   o_pc       : current PC
//   o_pc_next  : PC value that will be loaded at the next edge
module ysyx_22040895_pcreg
    import ysyx_22040895_ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  pc_sel_e           i_sel,
    input  logic [ADDR_W-1:0] i_dnpc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Next-PC mux; +4 wraps naturally at ADDR_W bits.
    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_INC:   w_pc_next = r_pc + ADDR_W'(4);
            PC_REDIR: w_pc_next = i_dnpc;
            default:  w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: issues one imem read at a time from the PC, hands
// the instruction and its PC to IDU over valid/ready, and follows EXU
// redirects, squashing the single outstanding wrong-path fetch.
//   clk, rst : clock, async active-high reset
//   bus      : ysyx_22040895_ifu_if.master (redirect, imem req/rsp, IDU stream)
module ysyx_22040895_ifu
    import ysyx_22040895_ifu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ysyx_22040895_ifu_if.master  bus
);

    ifu_state_e        r_state, w_state_next;
    logic              r_kill, w_kill_next;
    logic              r_req_valid, w_req_valid_next;
    logic [ADDR_W-1:0] r_req_addr, w_req_addr_next;
    logic              r_inst_valid, w_inst_valid_next;
    inst_pkt_t         r_out, w_out_next;
    pc_sel_e           w_pc_sel;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_next;

    ysyx_22040895_pcreg u_pcreg (
        .clk       (clk),
        .rst       (rst),
        .i_sel     (w_pc_sel),
        .i_dnpc    (bus.dnpc_i_ifu),
        .o_pc      (w_pc),
        .o_pc_next (w_pc_next)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IFU_IDLE;
            r_kill       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_out        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_kill       <= w_kill_next;
            r_req_valid  <= w_req_valid_next;
            r_req_addr   <= w_req_addr_next;
            r_inst_valid <= w_inst_valid_next;
            r_out        <= w_out_next;
        end
    end

    // Next state, PC select and next values of the output registers.
    always_comb begin
        w_state_next      = r_state;
        w_kill_next       = r_kill;
        w_inst_valid_next = r_inst_valid;
        w_out_next        = r_out;
        w_pc_sel          = PC_KEEP;
        w_req_valid_next  = 1'b0;
        w_req_addr_next   = r_req_addr;

        case (r_state)
            IFU_IDLE: begin
                w_state_next = IFU_REQ;
            end
            IFU_REQ: begin
                // A redirect while the request is presented makes that
                // request wrong-path; it is still completed, then dropped.
                if (bus.jump_branch_i_ifu) begin
                    w_pc_sel    = PC_REDIR;
                    w_kill_next = 1'b1;
                end
                if (bus.imem_req_ready_i) begin
                    w_state_next = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (bus.jump_branch_i_ifu) begin
                    w_pc_sel = PC_REDIR;
                    if (bus.imem_rsp_valid_i) begin
                        w_kill_next  = 1'b0;
                        w_state_next = IFU_REQ;
                    end else begin
                        w_kill_next = 1'b1;
                    end
                end else if (bus.imem_rsp_valid_i) begin
                    if (r_kill) begin
                        // PC already holds the redirect target.
                        w_kill_next  = 1'b0;
                        w_state_next = IFU_REQ;
                    end else begin
                        w_out_next.pc     = w_pc;
                        w_out_next.inst   = bus.imem_rsp_data_i;
                        w_inst_valid_next = 1'b1;
                        w_pc_sel          = PC_INC;
                        w_state_next      = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                if (bus.jump_branch_i_ifu) begin
                    w_pc_sel          = PC_REDIR;
                    w_inst_valid_next = 1'b0;
                    w_state_next      = IFU_REQ;
                end else if (bus.inst_ready_i) begin
                    w_inst_valid_next = 1'b0;
                    w_state_next      = IFU_REQ;
                end
            end
            default: begin
                w_state_next = IFU_IDLE;
            end
        endcase

        // The request address is captured only on entry to REQ, so a
        // redirect during REQ cannot move an address already presented.
        w_req_valid_next = (w_state_next == IFU_REQ);
        if ((w_state_next == IFU_REQ) && (r_state != IFU_REQ)) begin
            w_req_addr_next = w_pc_next;
        end
    end

    assign bus.imem_req_valid_o = r_req_valid;
    assign bus.imem_req_addr_o  = r_req_addr;
    assign bus.inst_valid_o     = r_inst_valid;
    assign bus.inst_o           = r_out.inst;
    assign bus.pc_o             = r_out.pc;

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Randomized bench for ysyx_22040895_ifu: a memory model with random accept
// and response delay, a randomly stalling IDU and random EXU redirects,
// checked cycle by cycle against a transaction-level fetch model.
module tb_ysyx_22040895_ifu;
    import ysyx_22040895_ifu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_22040895_ifu_if bus ();

    ysyx_22040895_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_deliv  = 0;

    // Fetch model: what should be on the bus in the coming cycle.
    bit          m_req_out;   // a request should be presented
    bit          m_wait;      // one request accepted, response pending
    bit          m_deliv;     // an instruction should be offered to IDU
    bit          m_wrong;     // the pending/presented request is wrong-path
    logic [63:0] m_pc;        // address for the next fresh request
    logic [63:0] m_req_addr;  // address of the presented / pending request
    logic [63:0] e_pc;
    logic [31:0] e_inst;

    // Memory model.
    bit mem_busy;
    int mem_cnt;

    // Stimulus knobs (percent probabilities, max response delay).
    int p_mready, p_iready, p_jb, max_dly;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.jump_branch_i_ifu = 1'b0;
        bus.dnpc_i_ifu        = '0;
        bus.imem_req_ready_i  = 1'b0;
        bus.imem_rsp_valid_i  = 1'b0;
        bus.imem_rsp_data_i   = '0;
        bus.inst_ready_i      = 1'b0;
    endtask

    task automatic check_outputs();
        chk("req_valid", 64'(bus.imem_req_valid_o), 64'(m_req_out));
        if (m_req_out) chk("req_addr", bus.imem_req_addr_o, m_req_addr);
        chk("inst_valid", 64'(bus.inst_valid_o), 64'(m_deliv));
        if (m_deliv) begin
            chk("pc_o", bus.pc_o, e_pc);
            chk("inst_o", 64'(bus.inst_o), 64'(e_inst));
        end
    endtask

    task automatic drive_inputs();
        logic [63:0] tgt;
        bus.imem_req_ready_i  = ($urandom_range(99) < p_mready);
        bus.inst_ready_i      = ($urandom_range(99) < p_iready);
        bus.jump_branch_i_ifu = ($urandom_range(99) < p_jb);
        case ($urandom_range(3))
            0:       tgt = 64'h0000_0000_8000_0100;
            1:       tgt = 64'h0000_0000_8000_0200;
            2:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
            default: tgt = {32'h0000_0000, 16'h8000, 16'($urandom_range(16'hFFFF)) & 16'hFFFC};
        endcase
        bus.dnpc_i_ifu       = tgt;
        bus.imem_rsp_data_i  = $urandom;
        bus.imem_rsp_valid_i = mem_busy && (mem_cnt == 0);
        // Stray response while an instruction is held: must be ignored.
        if (!mem_busy && m_deliv && ($urandom_range(7) == 0)) bus.imem_rsp_valid_i = 1'b1;
    endtask

    // Advance memory and fetch model across the coming clock edge.
    task automatic step();
        bit          jb    = bus.jump_branch_i_ifu;
        bit          rdy   = bus.imem_req_ready_i;
        bit          rsp   = bus.imem_rsp_valid_i;
        bit          irdy  = bus.inst_ready_i;
        logic [63:0] dnpc  = bus.dnpc_i_ifu;
        logic [31:0] data  = bus.imem_rsp_data_i;

        if (mem_busy) begin
            if (rsp) mem_busy = 1'b0;
            else     mem_cnt--;
        end else if (m_req_out && rdy) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(max_dly);
        end

        if (m_req_out) begin
            if (jb) begin
                m_pc    = dnpc;
                m_wrong = 1'b1;
            end
            if (rdy) begin
                m_req_out = 1'b0;
                m_wait    = 1'b1;
            end
        end else if (m_wait) begin
            if (rsp) begin
                m_wait = 1'b0;
                if (jb || m_wrong) begin
                    if (jb) m_pc = dnpc;
                    m_wrong    = 1'b0;
                    m_req_out  = 1'b1;
                    m_req_addr = m_pc;
                end else begin
                    m_deliv = 1'b1;
                    e_pc    = m_req_addr;
                    e_inst  = data;
                    m_pc    = m_req_addr + 64'd4;
                end
            end else if (jb) begin
                m_pc    = dnpc;
                m_wrong = 1'b1;
            end
        end else if (m_deliv) begin
            if (jb || irdy) begin
                if (irdy) n_deliv++;
                if (jb) m_pc = dnpc;
                m_deliv    = 1'b0;
                m_req_out  = 1'b1;
                m_req_addr = m_pc;
            end
        end else begin
            // First edge out of reset: fetch from the reset PC.
            m_req_out  = 1'b1;
            m_req_addr = m_pc;
        end
    endtask

    // Assert reset asynchronously, check reset values, release, prime model.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid_o), 64'd0);
        chk("rst_req_addr", bus.imem_req_addr_o, RESET_PC);
        chk("rst_inst_valid", 64'(bus.inst_valid_o), 64'd0);
        chk("rst_inst_o", 64'(bus.inst_o), 64'd0);
        chk("rst_pc_o", bus.pc_o, 64'd0);
        clear_inputs();
        mem_busy  = 1'b0;
        mem_cnt   = 0;
        m_req_out = 1'b0;
        m_wait    = 1'b0;
        m_deliv   = 1'b0;
        m_wrong   = 1'b0;
        m_pc      = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic run(input int n, input int mr, input int ir, input int jb,
                       input int dly, input bit rst_in_wait);
        bit rst_pending = rst_in_wait;
        p_mready = mr;
        p_iready = ir;
        p_jb     = jb;
        max_dly  = dly;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
            if (rst_pending && m_wait && (i > n / 2)) begin
                rst_pending = 1'b0;
                #2;
                do_reset();
                continue;
            end
            drive_inputs();
            step();
        end
        if (rst_pending) chk("rst_in_wait_reached", 64'd0, 64'd1);
    endtask

    initial begin
        clear_inputs();
        #2;
        do_reset();
        // Zero-wait memory, always-ready IDU: sequential fetch, one per 3 cycles.
        run(15, 100, 100, 0, 0, 1'b0);
        // IDU stalls while an instruction is held.
        run(8, 100, 0, 0, 0, 1'b0);
        run(6, 100, 100, 0, 0, 1'b0);
        // Slow memory with redirects.
        run(400, 40, 100, 20, 3, 1'b0);
        // Fully random traffic, with one asynchronous reset while waiting.
        run(3000, 60, 60, 12, 3, 1'b1);
        run(1500, 80, 70, 5, 2, 1'b0);
        chk("progress", 64'(n_deliv > 200), 64'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
